// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor that consumes DIGIT bits of the operands per
//   clock through a DIGIT-wide carry chain, finishing a WIDTH-bit operation in
//   N = WIDTH/DIGIT RUN cycles.
//
//   Ports
//     clk    : clock, all state on rising edge
//     rst_n  : asynchronous active-low reset
//     start  : operation request, sampled only in IDLE
//     sub    : 0 = a+b+c_in, 1 = a-b-c_in (c_in is then a borrow-in)
//     a, b   : operands, latched when start is accepted
//     c_in   : carry/borrow in, latched when start is accepted
//     busy   : high while the operation is running
//     done   : one-cycle pulse, result outputs valid
//     sum    : registered result, held until the next operation completes
//     c_out  : carry out of the MSB (subtract: 1 = no borrow)
//     ovf    : two's-complement overflow
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               c_out_reg, ovf_reg;

    logic               last_digit;
    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   psum;
    logic [WIDTH-1:0]   a_shift, b_shift;

    assign last_digit = (count_reg == CNT_W'(N - 1));

    // DIGIT-wide ripple over the low digit of the shifting operand registers.
    assign chain[0] = carry_reg;
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
        assign psum[gi]    = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
        assign chain[gi+1] = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
    end

    // A doubles as the result shift register: the consumed digit leaves at the
    // bottom while the partial sum enters at the top, so after N shifts a_reg
    // holds the full result. sum only ever receives the completed word.
    if (DIGIT < WIDTH) begin : g_shift
        assign a_shift = {psum, a_reg[WIDTH-1:DIGIT]};
        assign b_shift = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign a_shift = psum;
        assign b_shift = '0;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && start) begin
                // Subtraction is A + ~B + ~borrow_in.
                count_reg <= '0;
                a_reg     <= a;
                b_reg     <= sub ? ~b : b;
                carry_reg <= c_in ^ sub;
            end else if (state_reg == RUN) begin
                count_reg <= count_reg + 1'b1;
                a_reg     <= a_shift;
                b_reg     <= b_shift;
                carry_reg <= chain[DIGIT];
                if (last_digit) begin
                    sum_reg   <= a_shift;
                    c_out_reg <= chain[DIGIT];
                    // chain[DIGIT-1] is the carry into bit WIDTH-1 on the last digit.
                    ovf_reg   <= chain[DIGIT] ^ chain[DIGIT-1];
                end
            end
        end
    end

    assign sum   = sum_reg;
    assign c_out = c_out_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT 8-bit, 1 bit per cycle ----------------
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
    );

    // ---------------- DUT 4-bit, 2 bits per cycle ----------------
    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    serial_adder #(.WIDTH(4), .DIGIT(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
        .a(a4), .b(b4), .c_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .ovf(ovf4)
    );

    typedef struct {
        logic [7:0] sum;
        logic       c_out;
        logic       ovf;
        int         start_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    // Returns {ovf, c_out, sum[7:0]}.
    function automatic logic [9:0] model(input int w, input int a, input int b,
                                         input int ci, input int s);
        int r, sr, sa, sb, full;
        logic c, o;
        full = 1 << w;
        sa = (a >= full / 2) ? a - full : a;
        sb = (b >= full / 2) ? b - full : b;
        if (s != 0) begin
            r  = a - b - ci;
            sr = sa - sb - ci;
            c  = (r >= 0);
        end else begin
            r  = a + b + ci;
            sr = sa + sb + ci;
            c  = (r >= full);
        end
        o = (sr < -(full / 2)) || (sr > full / 2 - 1);
        return {o, c, 8'(r & (full - 1))};
    endfunction

    // ---------------- monitors ----------------
    exp_t e8, e4;
    int   bc8 = 0, bc4 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bc8 = 0;
        end else begin
            if (busy8) bc8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("u8_extra_done", done8, 0);
                end else begin
                    e8 = q8.pop_front();
                    $display("u8 done cyc=%0d sum=%h c_out=%b ovf=%b (exp %h %b %b)",
                             cyc, sum8, cout8, ovf8, e8.sum, e8.c_out, e8.ovf);
                    chk("u8_sum", sum8, e8.sum);
                    chk("u8_c_out", cout8, e8.c_out);
                    chk("u8_ovf", ovf8, e8.ovf);
                    chk("u8_latency", cyc - e8.start_cyc, 8);
                    chk("u8_busy_cycles", bc8, 8);
                    chk("u8_busy_in_done", busy8, 0);
                end
                bc8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bc4 = 0;
        end else begin
            if (busy4) bc4++;
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("u4_extra_done", done4, 0);
                end else begin
                    e4 = q4.pop_front();
                    $display("u4 done cyc=%0d sum=%h c_out=%b ovf=%b (exp %h %b %b)",
                             cyc, sum4, cout4, ovf4, e4.sum[3:0], e4.c_out, e4.ovf);
                    chk("u4_sum", {4'h0, sum4}, e4.sum);
                    chk("u4_c_out", cout4, e4.c_out);
                    chk("u4_ovf", ovf4, e4.ovf);
                    chk("u4_latency", cyc - e4.start_cyc, 2);
                    chk("u4_busy_cycles", bc4, 2);
                end
                bc4 = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic s, input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = ci; sub8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        q8.push_back('{es, ec, eo, cyc});
        // Operands must already be latched; scramble them.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                          input logic s, input logic [9:0] m);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = ci; sub4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        q4.push_back('{m[7:0], m[8], m[9], cyc});
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       ci, s;
        logic [7:0] es;
        logic       ec, eo;
    } dir_t;

    dir_t dir[5];

    initial begin
        logic [9:0] m;
        logic [7:0] ra, rb;
        logic       rc, rs;

        dir[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        dir[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        dir[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        dir[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        dir[4] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_sum4", sum4, 0);
        chk("rst_cout4", cout4, 0);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        for (int i = 0; i < 5; i++) begin
            issue8(dir[i].a, dir[i].b, dir[i].ci, dir[i].s, dir[i].es, dir[i].ec, dir[i].eo);
            repeat (8) @(negedge clk);
        end

        // Random 8-bit operations against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            m = model(8, int'(ra), int'(rb), int'(rc), int'(rs));
            issue8(ra, rb, rc, rs, m[7:0], m[8], m[9]);
            repeat (8) @(negedge clk);
        end

        // start and operand changes during RUN must not affect anything.
        issue8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (10) @(negedge clk);
        chk("ignored_start_pending", q8.size(), 0);

        // Reset in the middle of RUN.
        m = model(8, 'h3C, 'h5A, 1, 0);
        issue8(8'h3C, 8'h5A, 1'b1, 1'b0, m[7:0], m[8], m[9]);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_sum", sum8, 0);
        chk("midrst_cout", cout8, 0);
        chk("midrst_ovf", ovf8, 0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m = model(8, 'hC3, 'h4E, 1, 1);
        issue8(8'hC3, 8'h4E, 1'b1, 1'b1, m[7:0], m[8], m[9]);
        repeat (8) @(negedge clk);

        // Exhaustive 4-bit, 2 bits per cycle.
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    for (int is = 0; is < 2; is++) begin
                        m = model(4, ia, ib, ic, is);
                        issue4(4'(ia), 4'(ib), 1'(ic), 1'(is), m);
                        repeat (2) @(negedge clk);
                    end

        repeat (6) @(negedge clk);
        chk("u8_pending_at_end", q8.size(), 0);
        chk("u4_pending_at_end", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
